tdm_demux: RTL
==============

# tdm_demux

Serial time-division demultiplexer: receives one bit per clock on a single line carrying frames of CHANNELS slots of WIDTH bits each, and distributes each slot to its own parallel output word. It is the receive end of the mux-based TDM serializer: the serializer selects one channel per slot onto a shared wire, and this block steers the slots back out. A HUNT/LOCKED state machine tracks frame alignment from a frame-sync strobe. All channel outputs are updated together once per complete frame.

## Interface
- CHANNELS, 4: slots per frame (≥2).
- WIDTH, 8: bits per slot (≥1). Frame length L = CHANNELS*WIDTH cycles.
- clk  input  1  rising-edge clock; all logic synchronous to it.
- rst  input  1  reset, synchronous, active-high.
- din  input  1  serial data, one bit per cycle, MSB of each slot first, channel 0 first.
- frame_sync  input  1  high on the cycle carrying bit 0 of a frame (MSB of channel 0).
- ch_out  output  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]; registered.
- frame_valid  output  1  one-cycle pulse: ch_out just updated with a complete frame.
- locked  output  1  high while in LOCKED.
- sync_err  output  1  one-cycle pulse on a frame alignment violation.

## Operation
- Reset (rst sampled high): state HUNT, position counter p=0, shift register cleared, ch_out=0, frame_valid=0, locked=0, sync_err=0. rst overrides all other inputs on that edge; a partial frame in progress is discarded.
- Position counter p: 0..L-1; slot = p / WIDTH, bit within slot = p % WIDTH. Wraps L-1 → 0.
- HUNT: din ignored unless frame_sync=1. On frame_sync=1: din taken as frame position 0, p←1, state→LOCKED. No sync_err is raised in HUNT.
- LOCKED, each cycle, din shifted into the frame shift register at position p.
  - p≠0 and frame_sync=1: early sync. sync_err pulses, partial frame discarded, current bit taken as position 0, p←1, stay LOCKED.
  - p=0 and frame_sync=0: missing sync. sync_err pulses, bit discarded, p←0, state→HUNT.
  - p=0 and frame_sync=1: normal frame start, p←1.
  - p=L-1 (frame_sync=0): frame complete; on this edge ch_out loads the full frame (including this bit), p←0.
- ch_out holds its value between completed frames and is never partially updated; a discarded frame leaves ch_out unchanged.
- Bit mapping: the first WIDTH bits of the frame form ch_out[WIDTH-1:0] MSB first; slot k forms ch_out[k*WIDTH+WIDTH-1 : k*WIDTH].
- CHANNELS=1 is not supported; WIDTH=1 is legal (p counts slots directly).

## Timing
- Inputs sampled on rising clk edge.
- Latency: the edge sampling the last bit of a frame (p=L-1) updates ch_out; frame_valid is high for exactly the cycle following that edge.
- Back-to-back frames: frame_sync at p=0 on the cycle immediately following p=L-1 sustains LOCKED with no gap; frame_valid pulses once per L cycles.
- sync_err is high for the cycle following the offending edge; early sync and frame completion cannot coincide (frame_sync at p=L-1 is an early sync and the frame is discarded).
- locked rises the cycle after the first accepted frame_sync; falls the cycle after a missing-sync edge or reset.
- Minimum time from reset release to first frame_valid: L cycles after the first frame_sync.

## Test plan
- CHANNELS=4, WIDTH=8: after reset, send one frame A5,3C,FF,01 with frame_sync on first bit -> locked=1 one cycle later, ch_out=32'h01FF3CA5, single frame_valid pulse the cycle after bit 31, sync_err never high.
- Back-to-back frames 11,22,33,44 then 55,66,77,88 with no gap -> frame_valid exactly 32 cycles apart; ch_out 32'h44332211 then 32'h88776655; locked stays 1.
- Early sync: frame_sync reasserted at p=12 mid-frame, followed by a full frame 0A,0B,0C,0D -> one sync_err pulse, no frame_valid for the aborted frame, ch_out keeps its prior value, then becomes 32'h0D0C0B0A.
- Missing sync: frame_sync held low at expected p=0 -> sync_err pulse, locked=0 next cycle, ch_out unchanged; the next frame_sync re-locks and the following frame is delivered correctly.
- Reset mid-frame: rst high at p=17 for one cycle -> all outputs 0 the next cycle, state HUNT; din with frame_sync=0 ignored; no sync_err raised.
- Noise in HUNT: random din with frame_sync=0 for 100 cycles after reset -> ch_out=0, frame_valid=0, sync_err=0, locked=0 throughout.

Source files
------------

// File: rtl/tdm_demux_if.sv
// Serial TDM receive bus: one data bit and a frame-sync strobe in, the
// demultiplexed channel words and frame status out.
interface tdm_demux_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);

  logic                        din;
  logic                        frame_sync;
  logic [CHANNELS*WIDTH-1:0]   ch_out;
  logic                        frame_valid;
  logic                        locked;
  logic                        sync_err;

  // Line side: drives the serial stream, observes the channel words.
  modport master (
    output din,
    output frame_sync,
    input  ch_out,
    input  frame_valid,
    input  locked,
    input  sync_err
  );

  // Demultiplexer side.
  modport slave (
    input  din,
    input  frame_sync,
    output ch_out,
    output frame_valid,
    output locked,
    output sync_err
  );

endinterface

// File: rtl/tdm_demux.sv
// Serial time-division demultiplexer.
//
// A CHANNELS*WIDTH-bit frame arrives one bit per clock, MSB of channel 0
// first. A HUNT/LOCKED machine follows the frame-sync strobe; every
// complete frame is copied to ch_out in one step, so the parallel words
// never show a mix of two frames.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   HUNT   | no alignment; serial data ignored until frame_sync
//   LOCKED | aligned; p_q is the frame position of the current bit
module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux_if.slave   bus
);

  localparam int L  = CHANNELS * WIDTH;
  localparam int PW = (L > 1) ? $clog2(L) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(L - 1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);

  if (CHANNELS < 2) begin : g_bad_channels
    $error("tdm_demux: CHANNELS must be at least 2");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("tdm_demux: WIDTH must be at least 1");
  end

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   p_q;
  logic [L-1:0]    shift_q;
  logic [L-1:0]    ch_out_q;
  logic            frame_valid_q;
  logic            locked_q;
  logic            sync_err_q;

  logic [L-1:0]    shift_d;
  logic [L-1:0]    frame_d;

  // The shift register fills from the LSB end, so the earliest slot ends up
  // in the top WIDTH bits. Bit order inside a slot is already MSB-first.
  assign shift_d = {shift_q[L-2:0], bus.din};

  // Reverse slot order so channel k lands at ch_out[k*WIDTH +: WIDTH].
  always_comb begin
    frame_d = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      frame_d[k*WIDTH +: WIDTH] = shift_d[(CHANNELS-1-k)*WIDTH +: WIDTH];
    end
  end

  // Alignment state machine, position counter and registered outputs.
  // A discarded partial frame needs no explicit clearing: the next full
  // frame shifts L fresh bits through before ch_out is loaded again.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      p_q           <= '0;
      shift_q       <= '0;
      ch_out_q      <= '0;
      frame_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      case (state_q)
        HUNT: begin
          if (bus.frame_sync) begin
            shift_q  <= shift_d;
            p_q      <= P_ONE;
            state_q  <= LOCKED;
            locked_q <= 1'b1;
          end
        end
        LOCKED: begin
          shift_q <= shift_d;
          if ((p_q != '0) && bus.frame_sync) begin
            // Early sync: restart the frame on this bit.
            sync_err_q <= 1'b1;
            p_q        <= P_ONE;
          end else if ((p_q == '0) && !bus.frame_sync) begin
            // Expected frame start without a strobe: alignment lost.
            sync_err_q <= 1'b1;
            p_q        <= '0;
            state_q    <= HUNT;
            locked_q   <= 1'b0;
          end else if (p_q == P_LAST) begin
            ch_out_q      <= frame_d;
            frame_valid_q <= 1'b1;
            p_q           <= '0;
          end else begin
            p_q <= p_q + 1'b1;
          end
        end
        default: begin
          state_q  <= HUNT;
          locked_q <= 1'b0;
          p_q      <= '0;
        end
      endcase
    end
  end

  assign bus.ch_out      = ch_out_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.locked      = locked_q;
  assign bus.sync_err    = sync_err_q;

endmodule
